// File: rtl/branch_resolve_ctrl_if.sv
// Bus between ID/EX, IF and the EX-stage branch resolution controller.
// The master drives the branch and fetch-lookup fields; the slave returns control and redirect information.
interface branch_resolve_ctrl_if #(
  parameter int CNT_W = 16
) ();
  logic             br_valid;
  logic [31:0]      br_pc;
  logic [31:0]      br_imm;
  logic [2:0]       br_funct3;
  logic [31:0]      br_op1;
  logic [31:0]      br_op2;
  logic             ops_ready;
  logic             br_pred_taken;
  logic [31:0]      if_pc;
  logic             if_pred_taken;
  logic             stall_o;
  logic             br_done;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             flush_o;
  logic             illegal_cond;
  logic [CNT_W-1:0] mispredict_cnt;

  modport master (
    output br_valid, br_pc, br_imm, br_funct3, br_op1, br_op2, ops_ready, br_pred_taken, if_pc,
    input  if_pred_taken, stall_o, br_done, redirect_valid, redirect_pc, flush_o, illegal_cond,
           mispredict_cnt
  );

  modport slave (
    input  br_valid, br_pc, br_imm, br_funct3, br_op1, br_op2, ops_ready, br_pred_taken, if_pc,
    output if_pred_taken, stall_o, br_done, redirect_valid, redirect_pc, flush_o, illegal_cond,
           mispredict_cnt
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// EX-stage RV32I conditional-branch resolver: condition evaluation, redirect and multi-cycle flush.
// Optional 2-bit branch history table enabled by defining BRANCH_PRED_EN.
module branch_resolve_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int BHT_ENTRIES  = 64,
  parameter int CNT_W        = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  branch_resolve_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0]  FLUSH_LAST = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  function automatic logic cond_eval(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic res;
    case (f3)
      3'b000:  res = (a == b);
      3'b001:  res = (a != b);
      3'b100:  res = ($signed(a) < $signed(b));
      3'b101:  res = ($signed(a) >= $signed(b));
      3'b110:  res = (a < b);
      3'b111:  res = (a >= b);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  state_t           state_r;
  logic [FC_W-1:0]  flush_cnt_r;
  logic             br_done_r;
  logic             redirect_valid_r;
  logic [31:0]      redirect_pc_r;
  logic             flush_r;
  logic             illegal_r;
  logic [CNT_W-1:0] cnt_r;

  logic             accept_s;
  logic             taken_s;
  logic             illegal_s;
  logic             mispredict_s;
  logic [31:0]      sum_s;
  logic [31:0]      target_s;
  logic             unused_s;

  // Branch outcome and corrected target for the branch currently in EX.
  always_comb begin
    accept_s     = 1'b0;
    taken_s      = cond_eval(bus.br_funct3, bus.br_op1, bus.br_op2);
    illegal_s    = (bus.br_funct3 == 3'b010) || (bus.br_funct3 == 3'b011);
    mispredict_s = taken_s != bus.br_pred_taken;
    if (taken_s) begin
      sum_s = bus.br_pc + bus.br_imm;
    end else begin
      sum_s = bus.br_pc + 32'd4;
    end
    target_s = {sum_s[31:1], 1'b0};
    if ((state_r == IDLE) || (state_r == WAIT)) begin
      accept_s = bus.br_valid & bus.ops_ready;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Resolution FSM with registered pulses, redirect, flush window and mispredict statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= IDLE;
      flush_cnt_r      <= '0;
      br_done_r        <= 1'b0;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= 32'd0;
      flush_r          <= 1'b0;
      illegal_r        <= 1'b0;
      cnt_r            <= '0;
    end else begin
      br_done_r        <= 1'b0;
      redirect_valid_r <= 1'b0;
      illegal_r        <= 1'b0;
      case (state_r)
        IDLE, WAIT: begin
          if (accept_s) begin
            br_done_r <= 1'b1;
            illegal_r <= illegal_s;
            if (mispredict_s) begin
              redirect_valid_r <= 1'b1;
              redirect_pc_r    <= target_s;
              flush_r          <= 1'b1;
              flush_cnt_r      <= FLUSH_LAST;
              state_r          <= FLUSH;
              if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
              end
            end else begin
              state_r <= IDLE;
            end
          end else if (bus.br_valid) begin
            state_r <= WAIT;
          end else begin
            state_r <= IDLE;
          end
        end
        // Wrong-path branches arriving here are deliberately ignored.
        FLUSH: begin
          if (flush_cnt_r == '0) begin
            flush_r <= 1'b0;
            state_r <= IDLE;
          end else begin
            flush_cnt_r <= flush_cnt_r - {{(FC_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          flush_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.stall_o        = bus.br_valid & ~bus.ops_ready & (state_r != FLUSH);
  assign bus.br_done        = br_done_r;
  assign bus.redirect_valid = redirect_valid_r;
  assign bus.redirect_pc    = redirect_pc_r;
  assign bus.flush_o        = flush_r;
  assign bus.illegal_cond   = illegal_r;
  assign bus.mispredict_cnt = cnt_r;
  assign unused_s           = ^{bus.if_pc, 32'(IDX_W)};

`ifdef BRANCH_PRED_EN
  logic [1:0]       bht_r [BHT_ENTRIES];
  logic [IDX_W-1:0] wr_idx_s;
  logic [IDX_W-1:0] rd_idx_s;

  assign wr_idx_s = bus.br_pc[IDX_W+1:2];
  assign rd_idx_s = bus.if_pc[IDX_W+1:2];

  // Saturating 2-bit history update on every accepted branch; reads see the pre-update value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_r[i] <= 2'b01;
      end
    end else if (accept_s) begin
      if (taken_s && (bht_r[wr_idx_s] != 2'b11)) begin
        bht_r[wr_idx_s] <= bht_r[wr_idx_s] + 2'b01;
      end else if (!taken_s && (bht_r[wr_idx_s] != 2'b00)) begin
        bht_r[wr_idx_s] <= bht_r[wr_idx_s] - 2'b01;
      end
    end
  end

  assign bus.if_pred_taken = bht_r[rd_idx_s][1];
`else
  assign bus.if_pred_taken = 1'b0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed self-checking bench for branch_resolve_ctrl (default build; BHT scenario when BRANCH_PRED_EN is defined).
module tb_branch_resolve_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  branch_resolve_ctrl_if #(.CNT_W(16)) bus ();

  branch_resolve_ctrl #(
    .FLUSH_CYCLES(2),
    .BHT_ENTRIES (64),
    .CNT_W       (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_br(input logic [31:0] pc, input logic [31:0] imm, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input logic rdy, input logic pred);
    bus.br_valid      = 1'b1;
    bus.br_pc         = pc;
    bus.br_imm        = imm;
    bus.br_funct3     = f3;
    bus.br_op1        = a;
    bus.br_op2        = b;
    bus.ops_ready     = rdy;
    bus.br_pred_taken = pred;
  endtask

  task automatic wait_flush(output int n);
    n = 0;
    while ((bus.flush_o === 1'b1) && (n < 20)) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.br_valid = 1'b0; bus.br_pc = 32'd0; bus.br_imm = 32'd0; bus.br_funct3 = 3'd0;
    bus.br_op1 = 32'd0; bus.br_op2 = 32'd0; bus.ops_ready = 1'b0; bus.br_pred_taken = 1'b0;
    bus.if_pc = 32'h0000_0504;
    #3;
    checks++;
    if ({bus.br_done, bus.redirect_valid, bus.flush_o, bus.illegal_cond, bus.stall_o, bus.if_pred_taken} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: actual=%b required=000000",
               {bus.br_done, bus.redirect_valid, bus.flush_o, bus.illegal_cond, bus.stall_o, bus.if_pred_taken});
    end
    checks++;
    if (bus.redirect_pc !== 32'd0) begin
      failures++; $display("FAIL reset_redirect_pc: actual=%h required=00000000", bus.redirect_pc);
    end
    checks++;
    if (bus.mispredict_cnt !== 16'd0) begin
      failures++; $display("FAIL reset_cnt: actual=%0d required=0", bus.mispredict_cnt);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_signed_unsigned();
    set_br(32'h0000_0200, 32'h0000_0040, 3'b100, 32'd5, 32'hFFFF_FFFE, 1'b1, 1'b0);
    step();
    checks++;
    if ({bus.br_done, bus.redirect_valid, bus.flush_o} !== 3'b100) begin
      failures++; $display("FAIL blt_not_taken: actual=%b required=100", {bus.br_done, bus.redirect_valid, bus.flush_o});
    end
    set_br(32'h0000_0200, 32'h0000_0040, 3'b110, 32'd5, 32'hFFFF_FFFE, 1'b1, 1'b0);
    step();
    checks++;
    if ({bus.br_done, bus.redirect_valid, bus.flush_o} !== 3'b111) begin
      failures++; $display("FAIL bltu_taken_flags: actual=%b required=111", {bus.br_done, bus.redirect_valid, bus.flush_o});
    end
    checks++;
    if (bus.redirect_pc !== 32'h0000_0240) begin
      failures++; $display("FAIL bltu_redirect_pc: actual=%h required=00000240", bus.redirect_pc);
    end
    checks++;
    if (bus.mispredict_cnt !== 16'd1) begin
      failures++; $display("FAIL bltu_cnt: actual=%0d required=1", bus.mispredict_cnt);
    end
    bus.br_valid = 1'b0;
    step();
    checks++;
    if ({bus.br_done, bus.redirect_valid, bus.flush_o} !== 3'b001) begin
      failures++; $display("FAIL flush_second_cycle: actual=%b required=001", {bus.br_done, bus.redirect_valid, bus.flush_o});
    end
    checks++;
    if (bus.redirect_pc !== 32'h0000_0240) begin
      failures++; $display("FAIL redirect_pc_hold: actual=%h required=00000240", bus.redirect_pc);
    end
    step();
    checks++;
    if (bus.flush_o !== 1'b0) begin
      failures++; $display("FAIL flush_end: actual=%b required=0", bus.flush_o);
    end
  endtask

  task automatic test_target();
    int n;
    set_br(32'h0000_0100, 32'h0000_0020, 3'b000, 32'd7, 32'd7, 1'b1, 1'b0);
    step();
    checks++;
    if ((bus.redirect_valid !== 1'b1) || (bus.redirect_pc !== 32'h0000_0120)) begin
      failures++; $display("FAIL beq_taken_target: actual=%b/%h required=1/00000120", bus.redirect_valid, bus.redirect_pc);
    end
    bus.br_valid = 1'b0;
    wait_flush(n);
    checks++;
    if (n != 2) begin
      failures++; $display("FAIL flush_length: actual=%0d required=2", n);
    end
    set_br(32'h0000_0100, 32'h0000_0020, 3'b000, 32'd7, 32'd8, 1'b1, 1'b1);
    step();
    checks++;
    if ((bus.redirect_valid !== 1'b1) || (bus.redirect_pc !== 32'h0000_0104)) begin
      failures++; $display("FAIL beq_fallthrough_target: actual=%b/%h required=1/00000104", bus.redirect_valid, bus.redirect_pc);
    end
    checks++;
    if (bus.mispredict_cnt !== 16'd3) begin
      failures++; $display("FAIL target_cnt: actual=%0d required=3", bus.mispredict_cnt);
    end
    bus.br_valid = 1'b0;
    wait_flush(n);
  endtask

  task automatic test_stall();
    set_br(32'h0000_0300, 32'h0000_0008, 3'b001, 32'd1, 32'd2, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.stall_o !== 1'b1) begin
        failures++; $display("FAIL stall_high_%0d: actual=%b required=1", i, bus.stall_o);
      end
      step();
      checks++;
      if (bus.br_done !== 1'b0) begin
        failures++; $display("FAIL stall_no_done_%0d: actual=%b required=0", i, bus.br_done);
      end
    end
    bus.ops_ready = 1'b1;
    #1;
    checks++;
    if (bus.stall_o !== 1'b0) begin
      failures++; $display("FAIL stall_release: actual=%b required=0", bus.stall_o);
    end
    step();
    checks++;
    if ({bus.br_done, bus.redirect_valid} !== 2'b10) begin
      failures++; $display("FAIL wait_resolve: actual=%b required=10", {bus.br_done, bus.redirect_valid});
    end
  endtask

  task automatic test_back_to_back();
    int n;
    set_br(32'h0000_0310, 32'h0000_0010, 3'b101, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
    step();
    checks++;
    if ({bus.br_done, bus.redirect_valid} !== 2'b10) begin
      failures++; $display("FAIL b2b_first: actual=%b required=10", {bus.br_done, bus.redirect_valid});
    end
    set_br(32'h0000_0320, 32'h0000_0010, 3'b111, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1);
    step();
    checks++;
    if ({bus.br_done, bus.redirect_valid} !== 2'b10) begin
      failures++; $display("FAIL b2b_second: actual=%b required=10", {bus.br_done, bus.redirect_valid});
    end
    set_br(32'h0000_0330, 32'h0000_0010, 3'b100, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
    step();
    checks++;
    if ({bus.br_done, bus.redirect_valid, bus.redirect_pc} !== {2'b11, 32'h0000_0340}) begin
      failures++; $display("FAIL b2b_third: actual=%b%b/%h required=11/00000340", bus.br_done, bus.redirect_valid, bus.redirect_pc);
    end
    checks++;
    if (bus.mispredict_cnt !== 16'd4) begin
      failures++; $display("FAIL b2b_cnt: actual=%0d required=4", bus.mispredict_cnt);
    end
    bus.br_valid = 1'b0;
    wait_flush(n);
  endtask

  task automatic test_flush_ignore();
    set_br(32'hFFFF_FFF0, 32'h0000_0020, 3'b000, 32'd3, 32'd3, 1'b1, 1'b0);
    step();
    checks++;
    if ((bus.redirect_pc !== 32'h0000_0010) || (bus.mispredict_cnt !== 16'd5)) begin
      failures++; $display("FAIL wrap_target: actual=%h/%0d required=00000010/5", bus.redirect_pc, bus.mispredict_cnt);
    end
    set_br(32'h0000_0600, 32'h0000_0040, 3'b000, 32'd1, 32'd1, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus.stall_o !== 1'b0) begin
      failures++; $display("FAIL flush_no_stall: actual=%b required=0", bus.stall_o);
    end
    step();
    checks++;
    if ({bus.flush_o, bus.br_done} !== 2'b10) begin
      failures++; $display("FAIL flush_ignore_1: actual=%b required=10", {bus.flush_o, bus.br_done});
    end
    bus.ops_ready = 1'b1;
    step();
    checks++;
    if ({bus.flush_o, bus.br_done, bus.redirect_valid} !== 3'b000 || bus.mispredict_cnt !== 16'd5) begin
      failures++; $display("FAIL flush_ignore_2: actual=%b/%0d required=000/5",
                           {bus.flush_o, bus.br_done, bus.redirect_valid}, bus.mispredict_cnt);
    end
    bus.br_valid = 1'b0;
    step();
  endtask

  task automatic test_illegal_and_async_reset();
    set_br(32'h0000_0400, 32'h0000_0080, 3'b011, 32'd1, 32'd1, 1'b1, 1'b0);
    step();
    checks++;
    if ({bus.illegal_cond, bus.br_done, bus.redirect_valid} !== 3'b110 || bus.mispredict_cnt !== 16'd5) begin
      failures++; $display("FAIL illegal_pred0: actual=%b/%0d required=110/5",
                           {bus.illegal_cond, bus.br_done, bus.redirect_valid}, bus.mispredict_cnt);
    end
    set_br(32'h0000_0400, 32'h0000_0080, 3'b010, 32'd1, 32'd1, 1'b1, 1'b1);
    step();
    checks++;
    if ({bus.illegal_cond, bus.redirect_valid, bus.redirect_pc} !== {2'b11, 32'h0000_0404} || bus.mispredict_cnt !== 16'd6) begin
      failures++; $display("FAIL illegal_pred1: actual=%b%b/%h/%0d required=11/00000404/6",
                           bus.illegal_cond, bus.redirect_valid, bus.redirect_pc, bus.mispredict_cnt);
    end
    bus.br_valid = 1'b0;
    step();
    checks++;
    if ({bus.illegal_cond, bus.flush_o} !== 2'b01) begin
      failures++; $display("FAIL illegal_pulse_end: actual=%b required=01", {bus.illegal_cond, bus.flush_o});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.br_done, bus.redirect_valid, bus.flush_o, bus.illegal_cond, bus.stall_o} !== 5'b0 ||
        bus.redirect_pc !== 32'd0 || bus.mispredict_cnt !== 16'd0) begin
      failures++; $display("FAIL async_reset_flush: actual=%b/%h/%0d required=00000/00000000/0",
                           {bus.br_done, bus.redirect_valid, bus.flush_o, bus.illegal_cond, bus.stall_o},
                           bus.redirect_pc, bus.mispredict_cnt);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({bus.br_done, bus.flush_o} !== 2'b00) begin
      failures++; $display("FAIL post_reset_idle: actual=%b required=00", {bus.br_done, bus.flush_o});
    end
  endtask

`ifdef BRANCH_PRED_EN
  task automatic test_bht();
    logic tk [8];
    logic ex [8];
    tk = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ex = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    bus.if_pc = 32'h0000_0504;
    for (int i = 0; i < 8; i++) begin
      if (tk[i]) begin
        set_br(32'h0000_0504, 32'h0000_0008, 3'b000, 32'd1, 32'd1, 1'b1, 1'b1);
      end else begin
        set_br(32'h0000_0504, 32'h0000_0008, 3'b001, 32'd1, 32'd1, 1'b1, 1'b0);
      end
      if (i == 0) begin
        #1;
        checks++;
        if (bus.if_pred_taken !== 1'b0) begin
          failures++; $display("FAIL bht_no_bypass: actual=%b required=0", bus.if_pred_taken);
        end
      end
      step();
      checks++;
      if (bus.if_pred_taken !== ex[i]) begin
        failures++; $display("FAIL bht_step_%0d: actual=%b required=%b", i, bus.if_pred_taken, ex[i]);
      end
    end
    bus.br_valid = 1'b0;
    step();
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_signed_unsigned();
    test_target();
    test_stall();
    test_back_to_back();
    test_flush_ignore();
    test_illegal_and_async_reset();
`ifdef BRANCH_PRED_EN
    test_bht();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
